// File: rtl/wb_rr_arbiter.sv
// Round-robin writeback arbiter: picks one done unit per cycle into a
// one-entry registered output stage with valid/ready handshake.
module wb_rr_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int ID_WIDTH   = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_UNITS-1:0]            unit_done,
    input  logic [NUM_UNITS*ID_WIDTH-1:0]   unit_id,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_rd,
    output logic [NUM_UNITS-1:0]            unit_ack,
    input  logic                            wb_ready,
    output logic                            wb_valid,
    output logic [ID_WIDTH-1:0]             wb_id,
    output logic [DATA_WIDTH-1:0]           wb_data
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                  valid_q, valid_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;

    logic [NUM_UNITS-1:0]  rotated;
    logic                  load;
    logic                  found;
    logic [PTR_W:0]        sum;
    logic [PTR_W:0]        sel_inc;
    logic [PTR_W-1:0]      sel;
    logic [ID_WIDTH-1:0]   id_sel;
    logic [DATA_WIDTH-1:0] data_sel;

    always_comb begin
        // Rotating by ptr puts the highest-priority unit at bit 0.
        rotated = NUM_UNITS'({unit_done, unit_done} >> ptr_q);
        load    = ~rst & (~valid_q | wb_ready) & (|unit_done);
        found   = 1'b0;
        sum     = '0;
        sel     = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(NUM_UNITS)) begin
                    sum = sum - (PTR_W+1)'(NUM_UNITS);
                end
                sel = PTR_W'(sum);
            end
        end
    end

    always_comb begin
        unit_ack = '0;
        id_sel   = '0;
        data_sel = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (PTR_W'(i) == sel) begin
                unit_ack[i] = load;
                id_sel      = unit_id[i*ID_WIDTH +: ID_WIDTH];
                data_sel    = unit_rd[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        sel_inc = {1'b0, sel} + 1'b1;
        if (load) begin
            valid_d = 1'b1;
            id_d    = id_sel;
            data_d  = data_sel;
            ptr_d   = (sel_inc == (PTR_W+1)'(NUM_UNITS)) ? '0 : PTR_W'(sel_inc);
        end else if (valid_q && wb_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_id    = id_q;
    assign wb_data  = data_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (4 units): reset, single grant, fairness,
// back-pressure, wrap, reset during stall and drain.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    unit_done;
    logic [N*IW-1:0] unit_id;
    logic [N*DW-1:0] unit_rd;
    logic [N-1:0]    unit_ack;
    logic            wb_ready;
    logic            wb_valid;
    logic [IW-1:0]   wb_id;
    logic [DW-1:0]   wb_data;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    wb_rr_arbiter #(.NUM_UNITS(N), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .unit_done (unit_done),
        .unit_id   (unit_id),
        .unit_rd   (unit_rd),
        .unit_ack  (unit_ack),
        .wb_ready  (wb_ready),
        .wb_valid  (wb_valid),
        .wb_id     (wb_id),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, then let combinational ack settle.
    task automatic drive(input logic [N-1:0] done, input logic rdy);
        unit_done = done;
        wb_ready  = rdy;
        #1;
    endtask

    task automatic check_pkt(input string tag, input logic [IW-1:0] id, input logic [DW-1:0] data);
        check({tag, "_valid"}, {31'b0, wb_valid}, 32'd1);
        check({tag, "_id"}, {29'b0, wb_id}, {29'b0, id});
        check({tag, "_data"}, wb_data, data);
    endtask

    initial begin
        rst       = 1'b1;
        unit_done = '1;
        wb_ready  = 1'b1;
        for (int i = 0; i < N; i++) begin
            unit_id[i*IW +: IW] = IW'(i);
            unit_rd[i*DW +: DW] = 32'hA000_0000 + i;
        end

        // Reset with every unit done: no ack, cleared output register.
        #1;
        check("rst_ack", {28'b0, unit_ack}, 32'h0);
        step();
        step();
        check("rst_ack2", {28'b0, unit_ack}, 32'h0);
        check("rst_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_id", {29'b0, wb_id}, 32'd0);
        check("rst_data", wb_data, 32'd0);

        // Single request from unit 2.
        rst = 1'b0;
        unit_id[2*IW +: IW] = 3'd5;
        unit_rd[2*DW +: DW] = 32'hDEAD_BEEF;
        drive(4'b0100, 1'b1);
        check("single_ack", {28'b0, unit_ack}, 32'h4);
        step();
        check_pkt("single", 3'd5, 32'hDEAD_BEEF);

        // Drain: accepted with nothing pending, valid drops next cycle.
        drive(4'b0000, 1'b1);
        check("drain_ack", {28'b0, unit_ack}, 32'h0);
        step();
        check("drain_valid", {31'b0, wb_valid}, 32'd0);

        // ptr is still 3, so with all units done unit 3 wins, ptr wraps to 0.
        drive(4'b1111, 1'b1);
        check("ptr3_ack", {28'b0, unit_ack}, 32'h8);
        step();
        unit_id[2*IW +: IW] = 3'd2;
        unit_rd[2*DW +: DW] = 32'hA000_0002;

        // Fairness: eight back-to-back grants rotate 0..3 twice.
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 1'b1);
            check($sformatf("rr_ack%0d", c), {28'b0, unit_ack}, 32'h1 << (c % 4));
            step();
            check_pkt($sformatf("rr%0d", c), IW'(c % 4), 32'hA000_0000 + (c % 4));
        end
        drive(4'b0000, 1'b1);
        step();
        check("rr_drain", {31'b0, wb_valid}, 32'd0);

        // Back-pressure: packet from unit 1 (ptr -> 2), then stall 3 cycles.
        drive(4'b0010, 1'b1);
        check("bp_ack1", {28'b0, unit_ack}, 32'h2);
        step();
        for (int c = 0; c < 3; c++) begin
            drive(4'b1001, 1'b0);
            check($sformatf("bp_stall_ack%0d", c), {28'b0, unit_ack}, 32'h0);
            step();
            check_pkt($sformatf("bp_hold%0d", c), 3'd1, 32'hA000_0001);
        end
        drive(4'b1001, 1'b1);
        check("bp_ack3", {28'b0, unit_ack}, 32'h8);
        step();
        check_pkt("bp_u3", 3'd3, 32'hA000_0003);
        drive(4'b0001, 1'b1);
        check("bp_ack0", {28'b0, unit_ack}, 32'h1);
        step();
        check_pkt("bp_u0", 3'd0, 32'hA000_0000);
        drive(4'b0000, 1'b1);
        step();

        // Wrap: grant unit 2 (ptr -> 3), then unit 3 alone, then 0 beats 3.
        drive(4'b0100, 1'b1);
        step();
        drive(4'b1000, 1'b1);
        check("wrap_ack3", {28'b0, unit_ack}, 32'h8);
        step();
        drive(4'b1001, 1'b1);
        check("wrap_ack0", {28'b0, unit_ack}, 32'h1);
        step();
        check_pkt("wrap_u0", 3'd0, 32'hA000_0000);
        drive(4'b0000, 1'b1);
        step();

        // Reset mid-stall: packet from unit 0 (ptr -> 1) held, then reset.
        drive(4'b0001, 1'b1);
        step();
        drive(4'b0011, 1'b0);
        check("rs_stall_ack", {28'b0, unit_ack}, 32'h0);
        rst = 1'b1;
        #1;
        check("rs_rst_ack", {28'b0, unit_ack}, 32'h0);
        step();
        check("rs_valid", {31'b0, wb_valid}, 32'd0);
        rst = 1'b0;
        drive(4'b0011, 1'b1);
        check("rs_first_ack", {28'b0, unit_ack}, 32'h1);
        step();
        check_pkt("rs_u0", 3'd0, 32'hA000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter NUM_UNITS, default 4: number of writeback requesters; legal range 1..8.
REQ-002 Parameter ID_WIDTH, default 3: instruction-id width.
REQ-003 Parameter DATA_WIDTH, default 32: result width.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port unit_done, input, NUM_UNITS: per-unit result-available flag.
REQ-007 Port unit_id, input, NUM_UNITS*ID_WIDTH: per-unit instruction id; unit i occupies bits [i*ID_WIDTH +: ID_WIDTH].
REQ-008 Port unit_rd, input, NUM_UNITS*DATA_WIDTH: per-unit result; unit i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port unit_ack, output, NUM_UNITS: one-hot, combinational; unit i's result is consumed this cycle.
REQ-010 Port wb_ready, input, 1: downstream accepts the packet currently on wb_valid/wb_id/wb_data.
REQ-011 Port wb_valid, output, 1: registered packet valid.
REQ-012 Port wb_id, output, ID_WIDTH: registered packet id.
REQ-013 Port wb_data, output, DATA_WIDTH: registered packet data.

Function
REQ-014 The block SHALL hold a one-entry output register (valid, id, data) and a round-robin pointer ptr of width max(1,clog2(NUM_UNITS)).
REQ-015 The block SHALL define load = (~wb_valid | wb_ready) & (|unit_done).
REQ-016 The block SHALL select sel as the first index with unit_done set, searching ptr, ptr+1, ..., wrapping modulo NUM_UNITS.
REQ-017 The block SHALL assert unit_ack[sel] alone when load=1, and drive unit_ack to all zeros otherwise.
REQ-018 On load, the block SHALL capture unit_id[sel] and unit_rd[sel] into the output register, set wb_valid=1, and set ptr to (sel+1) mod NUM_UNITS.
REQ-019 When wb_valid=1, wb_ready=1 and no unit is done, the block SHALL clear wb_valid and leave ptr unchanged.
REQ-020 When wb_valid=1 and wb_ready=0, the block SHALL hold wb_valid, wb_id, wb_data and ptr unchanged and issue no ack.
REQ-021 Latency: unit_done at cycle t with the output register empty or draining SHALL give ack at cycle t and wb_valid at cycle t+1.
REQ-022 With wb_ready held high and requests continuously present, the block SHALL sustain one packet per cycle.
REQ-023 A unit SHALL be acked at most once per done assertion; a unit deasserting done without an ack SHALL have no effect.
REQ-024 With all units continuously done, grants SHALL rotate 0,1,...,NUM_UNITS-1,0. No unit SHALL wait more than NUM_UNITS accepted packets.
REQ-025 When NUM_UNITS=1, ptr SHALL be held at 0 and unit 0 SHALL be acked whenever load=1.
REQ-026 When ptr=NUM_UNITS-1 and sel=NUM_UNITS-1, ptr SHALL wrap to 0.
REQ-027 wb_id and wb_data SHALL be don't-care while wb_valid=0; the verifier SHALL not check them then.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set wb_valid=0 and ptr=0; wb_id and wb_data SHALL reset to 0.
REQ-029 While rst=1, unit_ack SHALL be all zeros regardless of unit_done.
REQ-030 Reset asserted with a stalled packet held (wb_ready=0) SHALL discard that packet without an ack; reset has priority over load.
REQ-031 After rst deasserts, the first grant SHALL start its search at unit 0.

Verification
REQ-032 Single request: reset, then unit 2 done with id=5, rd=0xDEADBEEF, wb_ready=1 -> unit_ack=4'b0100 same cycle; next cycle wb_valid=1, wb_id=5, wb_data=0xDEADBEEF; ptr=3.
REQ-033 Fairness: all four units done for 8 cycles, wb_ready=1 -> ack order 0,1,2,3,0,1,2,3; wb_valid=1 from cycle 2 through 9.
REQ-034 Back-pressure: packet held from unit 1, wb_ready=0 for 3 cycles with units 0 and 3 done -> no acks; outputs stable. When wb_ready=1, unit 3 is acked before unit 0 (ptr=2).
REQ-035 Wrap: ptr=3, only unit 3 done -> ack 4'b1000; ptr becomes 0. Next, units 0 and 3 done -> unit 0 acked.
REQ-036 Reset mid-stall: wb_valid=1, wb_ready=0, units 0 and 1 done, rst=1 for one cycle -> unit_ack=0 during reset; wb_valid=0 after. The next grant goes to unit 0.
REQ-037 Drain: single packet accepted with no further requests -> wb_valid drops the cycle after wb_ready=1; ptr is unchanged.
